// File: rtl/shifter_imm_encoder_pkg.sv
// Shared shifter-operand definitions for the ARM immediate encoder and the val2 decode.
// Holds field positions, shift types, FSM encodings and the rotate helpers.
package shifter_imm_encoder_pkg;

  typedef enum logic [1:0] {
    SHIFTTYPE_LSL = 2'b00,
    SHIFTTYPE_LSR = 2'b01,
    SHIFTTYPE_ASR = 2'b10,
    SHIFTTYPE_ROR = 2'b11
  } shift_type_e;

  localparam int unsigned ROT_MSB   = 11;
  localparam int unsigned ROT_LSB   = 8;
  localparam int unsigned IMM8_MSB  = 7;
  localparam int unsigned OPERAND_W = 12;
  localparam int unsigned ROT_W     = 4;
  localparam int unsigned ROT_MAX   = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_DONE   = 2'b10
  } enc_state_e;

  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] amt);
    logic [63:0] d;
    d = {v, v} << amt;
    return d[63:32];
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
    logic [63:0] d;
    d = {v, v} >> amt;
    return d[31:0];
  endfunction

endpackage

// File: rtl/shifter_imm_encoder_if.sv
// Handshake bundle for the immediate encoder: request side (in_*) and result side (out_*).
interface shifter_imm_encoder_if;
  import shifter_imm_encoder_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [OPERAND_W-1:0] out_operand;
  logic                 out_found;
  logic                 out_inverted;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_operand, out_found, out_inverted
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_operand, out_found, out_inverted
  );

endinterface

// File: rtl/shifter_imm_encoder_imm_rot_check.sv
// Combinational test of one rotation: does value ROL (2*rot) fit in 8 bits, and what is that byte.
module imm_rot_check
  import shifter_imm_encoder_pkg::*;
(
  input  logic [31:0]      value_i,
  input  logic [ROT_W-1:0] rot_i,
  output logic             fits_o,
  output logic [7:0]       imm8_o
);

  logic [31:0] cand;

  always_comb begin
    cand   = rol32(value_i, {rot_i, 1'b0});
    fits_o = (cand[31:IMM8_MSB+1] == '0);
    imm8_o = cand[IMM8_MSB:0];
  end

endmodule

// File: rtl/shifter_imm_encoder.sv
// Iterative ARM rotated-immediate encoder: tries one even rotation per cycle, smallest first,
// returning {rotate_imm, immed_8} and optionally the MVN (inverted) form.
module shifter_imm_encoder
  import shifter_imm_encoder_pkg::*;
#(
  parameter int unsigned CHECK_INVERTED = 1
) (
  input  logic clk,
  input  logic rst,
  shifter_imm_encoder_if.slave bus
);

  enc_state_e           state_q, state_d;
  logic [31:0]          value_q, value_d;
  logic [ROT_W-1:0]     rot_cnt_q, rot_cnt_d;
  logic [OPERAND_W-1:0] operand_q, operand_d;
  logic                 found_q, found_d;
  logic                 inverted_q, inverted_d;

  logic       dir_fits, inv_fits;
  logic [7:0] dir_imm8, inv_imm8;

  imm_rot_check u_dir (
    .value_i (value_q),
    .rot_i   (rot_cnt_q),
    .fits_o  (dir_fits),
    .imm8_o  (dir_imm8)
  );

  generate
    if (CHECK_INVERTED != 0) begin : g_inv
      imm_rot_check u_inv (
        .value_i (~value_q),
        .rot_i   (rot_cnt_q),
        .fits_o  (inv_fits),
        .imm8_o  (inv_imm8)
      );
    end else begin : g_no_inv
      assign inv_fits = 1'b0;
      assign inv_imm8 = '0;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    rot_cnt_d  = rot_cnt_q;
    operand_d  = operand_q;
    found_d    = found_q;
    inverted_d = inverted_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          value_d   = bus.in_value;
          rot_cnt_d = '0;
          state_d   = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        // Direct hit is checked first so it wins over the inverted form at the same rotation.
        if (dir_fits) begin
          operand_d[ROT_MSB:ROT_LSB] = rot_cnt_q;
          operand_d[IMM8_MSB:0]      = dir_imm8;
          found_d    = 1'b1;
          inverted_d = 1'b0;
          state_d    = ST_DONE;
        end else if (inv_fits) begin
          operand_d[ROT_MSB:ROT_LSB] = rot_cnt_q;
          operand_d[IMM8_MSB:0]      = inv_imm8;
          found_d    = 1'b1;
          inverted_d = 1'b1;
          state_d    = ST_DONE;
        end else if (rot_cnt_q == ROT_W'(ROT_MAX)) begin
          operand_d  = '0;
          found_d    = 1'b0;
          inverted_d = 1'b0;
          state_d    = ST_DONE;
        end else begin
          rot_cnt_d = rot_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      value_q    <= '0;
      rot_cnt_q  <= '0;
      operand_q  <= '0;
      found_q    <= 1'b0;
      inverted_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      rot_cnt_q  <= rot_cnt_d;
      operand_q  <= operand_d;
      found_q    <= found_d;
      inverted_q <= inverted_d;
    end
  end

  assign bus.in_ready     = (state_q == ST_IDLE);
  assign bus.out_valid    = (state_q == ST_DONE);
  assign bus.out_operand  = operand_q;
  assign bus.out_found    = found_q;
  assign bus.out_inverted = inverted_q;

endmodule
